// File: rtl/mac_multich_controller.sv
`default_nettype none
// ============================================================================
// mac_multich_controller : credit-tracked round-robin scheduler for a shared MAC
// Revision: 1.0
// ============================================================================
module mac_multich_controller #(
  parameter int ADDR_LINES = 5,
  parameter int N_CH       = 4,
  parameter int CREDIT_W   = 6,
  parameter int DONE_DELAY = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic                    mac_credit_clk_i,
  input  logic                    rstn_i,
  input  logic [N_CH-1:0]         fifo_wr_i,
  input  logic                    stop_i,
  input  logic [ADDR_LINES-1:0]   terms_i,
  input  logic                    mul_done_i,
  input  logic                    add_done_i,
  output logic                    mul_valid_o,
  output logic                    add_valid_o,
  output logic                    dp_reset_o,
  output logic [N_CH-1:0]         rd_signal_o,
  output logic                    rd_coeff_o,
  output logic                    load_result_o,
  output logic [$clog2(N_CH)-1:0] ch_sel_o,
  output logic [ADDR_LINES-1:0]   coeff_addr_o,
  output logic                    done_o,
  output logic [$clog2(N_CH)-1:0] done_ch_o,
  output logic [N_CH-1:0]         credit_ovf_o,
  output logic                    timeout_o
);

  localparam int CH_W = $clog2(N_CH);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_RESET_DP   = 4'd1,
    S_LOAD_SIG   = 4'd2,
    S_LOAD_COEFF = 4'd3,
    S_MUL        = 4'd4,
    S_WAIT_MUL   = 4'd5,
    S_ADD        = 4'd6,
    S_WAIT_ADD   = 4'd7,
    S_CHECK      = 4'd8,
    S_STORE      = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CH_W-1:0]       rr_q, rr_d;
  logic [ADDR_LINES-1:0] terms_q, terms_d;
  logic [ADDR_LINES-1:0] term_cnt_q, term_cnt_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  timeout_q, timeout_d;

  logic [CREDIT_W-1:0]   credit_q [N_CH];
  logic [CREDIT_W-1:0]   credit_d [N_CH];
  logic [N_CH-1:0]       ovf_q, ovf_d;
  logic [N_CH-1:0]       req;

  logic [DONE_DELAY-1:0] dv_q;
  logic [CH_W-1:0]       dch_q [DONE_DELAY];

  logic [CH_W-1:0]       grant_ch, scan_ch;
  logic                  grant_vld, grant_en;

  assign rd_signal_o  = (state_q == S_LOAD_SIG) ? (N_CH'(1) << ch_q) : '0;
  assign ch_sel_o     = ch_q;
  assign credit_ovf_o = ovf_q;
  assign timeout_o    = timeout_q;
  assign done_o       = dv_q[DONE_DELAY-1];
  assign done_ch_o    = dv_q[DONE_DELAY-1] ? dch_q[DONE_DELAY-1] : '0;
  assign coeff_addr_o = (state_q == S_IDLE) ? (terms_i - ADDR_LINES'(1))
                                            : (terms_q - ADDR_LINES'(1) - term_cnt_q);

  always_comb begin
    req = '0;
    for (int c = 0; c < N_CH; c++) begin
      req[c] = (credit_q[c] != '0);
    end
  end

  // A simultaneous write and read on a channel cancel out, even at saturation
  always_comb begin
    ovf_d = ovf_q;
    for (int c = 0; c < N_CH; c++) begin
      credit_d[c] = credit_q[c];
      if (fifo_wr_i[c] && !rd_signal_o[c]) begin
        if (credit_q[c] == {CREDIT_W{1'b1}}) begin
          ovf_d[c] = 1'b1;
        end else begin
          credit_d[c] = credit_q[c] + CREDIT_W'(1);
        end
      end else if (rd_signal_o[c] && !fifo_wr_i[c]) begin
        credit_d[c] = credit_q[c] - CREDIT_W'(1);
      end
    end
  end

  // Scan from the highest offset down so the channel nearest rr_q wins
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    scan_ch   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      scan_ch = CH_W'((int'(rr_q) + i) % N_CH);
      if (req[scan_ch]) begin
        grant_vld = 1'b1;
        grant_ch  = scan_ch;
      end
    end
  end

  assign grant_en = ((state_q == S_IDLE) || (state_q == S_STORE)) &&
                    !stop_i && (terms_i != '0) && grant_vld;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    rr_d          = rr_q;
    terms_d       = terms_q;
    term_cnt_d    = term_cnt_q;
    wd_d          = '0;
    timeout_d     = timeout_q;
    mul_valid_o   = 1'b0;
    add_valid_o   = 1'b0;
    dp_reset_o    = 1'b0;
    rd_coeff_o    = 1'b0;
    load_result_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_en) state_d = S_RESET_DP;
      end
      S_RESET_DP: begin
        dp_reset_o = 1'b1;
        state_d    = S_LOAD_SIG;
      end
      S_LOAD_SIG: begin
        state_d = S_LOAD_COEFF;
      end
      S_LOAD_COEFF: begin
        rd_coeff_o = 1'b1;
        state_d    = S_MUL;
      end
      S_MUL: begin
        mul_valid_o = 1'b1;
        state_d     = S_WAIT_MUL;
      end
      S_WAIT_MUL: begin
        if (mul_done_i) begin
          state_d = S_ADD;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ADD: begin
        add_valid_o = 1'b1;
        state_d     = S_WAIT_ADD;
      end
      S_WAIT_ADD: begin
        if (add_done_i) begin
          state_d = S_CHECK;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_CHECK: begin
        if (term_cnt_q < (terms_q - ADDR_LINES'(1))) begin
          term_cnt_d = term_cnt_q + ADDR_LINES'(1);
          state_d    = S_LOAD_COEFF;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        load_result_o = 1'b1;
        state_d       = grant_en ? S_RESET_DP : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (grant_en) begin
      ch_d       = grant_ch;
      rr_d       = CH_W'((int'(grant_ch) + 1) % N_CH);
      terms_d    = terms_i;
      term_cnt_d = '0;
    end
  end

  always_ff @(posedge mac_credit_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      rr_q       <= '0;
      terms_q    <= '0;
      term_cnt_q <= '0;
      wd_q       <= '0;
      timeout_q  <= 1'b0;
      ovf_q      <= '0;
      dv_q       <= '0;
      for (int c = 0; c < N_CH; c++) credit_q[c] <= '0;
      for (int i = 0; i < DONE_DELAY; i++) dch_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      rr_q       <= rr_d;
      terms_q    <= terms_d;
      term_cnt_q <= term_cnt_d;
      wd_q       <= wd_d;
      timeout_q  <= timeout_d;
      ovf_q      <= ovf_d;
      for (int c = 0; c < N_CH; c++) credit_q[c] <= credit_d[c];
      dv_q[0]  <= (state_q == S_STORE);
      dch_q[0] <= ch_q;
      for (int i = 1; i < DONE_DELAY; i++) begin
        dv_q[i]  <= dv_q[i-1];
        dch_q[i] <= dch_q[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_multich_controller.sv
`default_nettype none
// tb_mac_multich_controller : directed self-checking bench for the MAC channel scheduler
module tb_mac_multich_controller;

  localparam int ADDR_LINES = 5;
  localparam int N_CH       = 4;
  localparam int CREDIT_W   = 6;
  localparam int DONE_DELAY = 5;
  localparam int TIMEOUT    = 255;

  logic                  clk;
  logic                  rstn;
  logic [N_CH-1:0]       fifo_wr;
  logic                  stop;
  logic [ADDR_LINES-1:0] terms;
  logic                  mul_done;
  logic                  add_done;
  logic                  mul_valid, add_valid, dp_reset, rd_coeff, load_result, done, timeout;
  logic [N_CH-1:0]       rd_sig, credit_ovf;
  logic [1:0]            ch_sel, done_ch;
  logic [ADDR_LINES-1:0] coeff_addr;

  mac_multich_controller #(
    .ADDR_LINES(ADDR_LINES), .N_CH(N_CH), .CREDIT_W(CREDIT_W),
    .DONE_DELAY(DONE_DELAY), .TIMEOUT(TIMEOUT)
  ) dut (
    .mac_credit_clk_i(clk),
    .rstn_i          (rstn),
    .fifo_wr_i       (fifo_wr),
    .stop_i          (stop),
    .terms_i         (terms),
    .mul_done_i      (mul_done),
    .add_done_i      (add_done),
    .mul_valid_o     (mul_valid),
    .add_valid_o     (add_valid),
    .dp_reset_o      (dp_reset),
    .rd_signal_o     (rd_sig),
    .rd_coeff_o      (rd_coeff),
    .load_result_o   (load_result),
    .ch_sel_o        (ch_sel),
    .coeff_addr_o    (coeff_addr),
    .done_o          (done),
    .done_ch_o       (done_ch),
    .credit_ovf_o    (credit_ovf),
    .timeout_o       (timeout)
  );

  typedef struct {
    logic [ADDR_LINES-1:0] terms;
    logic [ADDR_LINES-1:0] exp_addr;
  } idle_vec_t;

  typedef struct {
    int ch;
    int terms;
    int mlat;
    int alat;
    int exp_len;
    int exp_first;
  } job_vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int mul_lat = 1, add_lat = 1, mcnt = 0, acnt = 0;
  int n_dprst, n_rdcoeff, n_mulv, n_addv, n_load, n_done, n_b2b, n_multi;
  int n_rdsig [N_CH];
  int last_dprst_cyc, last_load_cyc, last_done_cyc, last_done_ch, last_mulv_cyc, to_cyc;
  int grant_q[$];
  int addr_q[$];
  logic prev_load = 1'b0;
  logic prev_to   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 1ms");
    $fatal(1, "time limit");
  end

  // Datapath model and event monitor, both on the falling edge
  initial begin
    mul_done = 1'b0;
    add_done = 1'b0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) mul_done = 1'b1;
      end
      if (mul_valid && mul_lat > 0) mcnt = mul_lat;
      add_done = 1'b0;
      if (acnt > 0) begin
        acnt--;
        if (acnt == 0) add_done = 1'b1;
      end
      if (add_valid && add_lat > 0) acnt = add_lat;
      if (rstn) begin
        if (dp_reset) begin
          n_dprst++;
          last_dprst_cyc = cyc;
          if (prev_load) n_b2b++;
        end
        if (rd_sig != '0) begin
          if ($countones(rd_sig) != 1) n_multi++;
          for (int c = 0; c < N_CH; c++) begin
            if (rd_sig[c]) begin
              n_rdsig[c]++;
              grant_q.push_back(c);
            end
          end
        end
        if (rd_coeff) begin
          n_rdcoeff++;
          addr_q.push_back(int'(coeff_addr));
        end
        if (mul_valid) begin
          n_mulv++;
          last_mulv_cyc = cyc;
        end
        if (add_valid) n_addv++;
        if (load_result) begin
          n_load++;
          last_load_cyc = cyc;
        end
        if (done) begin
          n_done++;
          last_done_cyc = cyc;
          last_done_ch  = int'(done_ch);
        end
        if (timeout && !prev_to) to_cyc = cyc;
        prev_load = load_result;
        prev_to   = timeout;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_mon();
    n_dprst = 0; n_rdcoeff = 0; n_mulv = 0; n_addv = 0; n_load = 0;
    n_done = 0; n_b2b = 0; n_multi = 0;
    for (int c = 0; c < N_CH; c++) n_rdsig[c] = 0;
    last_dprst_cyc = -1; last_load_cyc = -1; last_done_cyc = -1;
    last_done_ch = -1; last_mulv_cyc = -1; to_cyc = -1;
    grant_q.delete();
    addr_q.delete();
  endtask

  task automatic wait_done(input int n, input int budget, input string name);
    int k = 0;
    while (n_done < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, longint'(n_done >= n), 1);
  endtask

  task automatic wait_dprst(input int n, input int budget, input string name);
    int k = 0;
    while (n_dprst < n && k < budget) begin
      tick(1);
      k++;
    end
    check(name, longint'(n_dprst >= n), 1);
  endtask

  idle_vec_t idle_tab [5];
  job_vec_t  job_tab  [5];

  initial begin
    int k;
    int bad;
    int c0;
    int exp_order [8];

    idle_tab[0] = '{5'd0,  5'd31};
    idle_tab[1] = '{5'd1,  5'd0};
    idle_tab[2] = '{5'd3,  5'd2};
    idle_tab[3] = '{5'd16, 5'd15};
    idle_tab[4] = '{5'd31, 5'd30};
    // length = load_result cycle - dp_reset cycle = 2 + terms*(4+mlat+alat)
    job_tab[0] = '{0, 3,  1, 1, 20,  2};
    job_tab[1] = '{1, 1,  1, 1, 8,   0};
    job_tab[2] = '{2, 4,  3, 2, 38,  3};
    job_tab[3] = '{3, 2,  2, 5, 24,  1};
    job_tab[4] = '{3, 31, 1, 1, 188, 30};
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    clear_mon();
    fifo_wr = '0;
    stop    = 1'b0;
    terms   = 5'd3;
    rstn    = 1'b1;
    #1 rstn = 1'b0;
    tick(3);

    // Reset state
    check("rst_mul_valid", mul_valid, 0);
    check("rst_add_valid", add_valid, 0);
    check("rst_dp_reset", dp_reset, 0);
    check("rst_rd_signal", rd_sig, 0);
    check("rst_rd_coeff", rd_coeff, 0);
    check("rst_load_result", load_result, 0);
    check("rst_ch_sel", ch_sel, 0);
    check("rst_done", done, 0);
    check("rst_done_ch", done_ch, 0);
    check("rst_credit_ovf", credit_ovf, 0);
    check("rst_timeout", timeout, 0);
    check("rst_coeff_addr", coeff_addr, 2);

    rstn = 1'b1;
    stop = 1'b1;
    tick(2);

    // IDLE address follows terms_i-1 with wrap
    for (int i = 0; i < 5; i++) begin
      terms = idle_tab[i].terms;
      #1;
      check($sformatf("idle_addr%0d", i), coeff_addr, idle_tab[i].exp_addr);
    end
    tick(1);

    // Single jobs with varied term counts and datapath latencies
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      mul_lat = job_tab[i].mlat;
      add_lat = job_tab[i].alat;
      terms   = ADDR_LINES'(job_tab[i].terms);
      stop    = 1'b0;
      fifo_wr = N_CH'(1) << job_tab[i].ch;
      tick(1);
      fifo_wr = '0;
      wait_dprst(1, 10, $sformatf("job%0d_started", i));
      terms = 5'd7;
      wait_done(1, 600, $sformatf("job%0d_done_seen", i));
      tick(3);
      check($sformatf("job%0d_len", i), last_load_cyc - last_dprst_cyc, job_tab[i].exp_len);
      check($sformatf("job%0d_rd_coeff", i), n_rdcoeff, job_tab[i].terms);
      check($sformatf("job%0d_mul_valid", i), n_mulv, job_tab[i].terms);
      check($sformatf("job%0d_rd_signal", i), n_rdsig[job_tab[i].ch], 1);
      check($sformatf("job%0d_done_delay", i), last_done_cyc - last_load_cyc, DONE_DELAY);
      check($sformatf("job%0d_done_ch", i), last_done_ch, job_tab[i].ch);
      check($sformatf("job%0d_addr_count", i), addr_q.size(), job_tab[i].terms);
      if (addr_q.size() > 0) begin
        check($sformatf("job%0d_addr_first", i), addr_q[0], job_tab[i].exp_first);
        bad = 0;
        foreach (addr_q[j]) if (addr_q[j] != job_tab[i].exp_first - j) bad++;
        check($sformatf("job%0d_addr_seq_errors", i), bad, 0);
      end
    end

    // Two samples on every channel: rotation and back-to-back jobs
    clear_mon();
    stop    = 1'b1;
    terms   = 5'd1;
    fifo_wr = 4'hF;
    tick(2);
    fifo_wr = '0;
    stop    = 1'b0;
    wait_done(8, 200, "rr_done_seen");
    tick(10);
    check("rr_grant_count", grant_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_q.size()) check($sformatf("rr_grant%0d", i), grant_q[i], exp_order[i]);
    end
    check("rr_back_to_back", n_b2b, 7);
    check("rr_onehot_errors", n_multi, 0);
    check("rr_last_done_ch", last_done_ch, 3);

    // Write and read on ch1 in the same cycle keep the credit
    clear_mon();
    k = 0;
    fifo_wr = 4'b0010;
    tick(1);
    fifo_wr = '0;
    while (!rd_sig[1] && k < 20) begin
      tick(1);
      k++;
    end
    check("same_cycle_rd_seen", rd_sig[1], 1);
    fifo_wr = 4'b0010;
    tick(1);
    fifo_wr = '0;
    wait_done(2, 100, "same_cycle_done_seen");
    tick(15);
    check("same_cycle_jobs", n_rdsig[1], 2);
    check("same_cycle_done_count", n_done, 2);
    check("same_cycle_no_ovf", credit_ovf, 0);

    // Credit saturation on ch2 while stopped
    clear_mon();
    stop    = 1'b1;
    fifo_wr = 4'b0100;
    tick(63);
    check("sat_ovf_before", credit_ovf, 0);
    tick(1);
    fifo_wr = '0;
    check("sat_ovf_set", credit_ovf, 4'b0100);
    tick(3);
    check("sat_stop_blocks", n_dprst, 0);
    stop = 1'b0;
    wait_done(63, 1500, "sat_done_seen");
    tick(30);
    check("sat_jobs", n_rdsig[2], 63);
    check("sat_done_count", n_done, 63);
    check("sat_back_to_back", n_b2b, 62);
    check("sat_ovf_sticky", credit_ovf, 4'b0100);

    // Multiplier never answers: watchdog abort
    clear_mon();
    mul_lat = 0;
    terms   = 5'd2;
    fifo_wr = 4'b0001;
    tick(1);
    fifo_wr = '0;
    k = 0;
    while (!timeout && k < 400) begin
      tick(1);
      k++;
    end
    check("wd_timeout_set", timeout, 1);
    tick(20);
    check("wd_latency", to_cyc - last_mulv_cyc, TIMEOUT + 1);
    check("wd_no_load", n_load, 0);
    check("wd_no_done", n_done, 0);
    check("wd_rd_coeff", n_rdcoeff, 1);
    terms = 5'd9;
    #1;
    check("wd_idle_addr", coeff_addr, 8);
    clear_mon();
    mul_lat = 1;
    terms   = 5'd1;
    fifo_wr = 4'b0001;
    tick(1);
    fifo_wr = '0;
    wait_done(1, 50, "wd_recover_done_seen");
    tick(20);
    check("wd_credit_spent_once", n_rdsig[0], 1);
    check("wd_timeout_sticky", timeout, 1);

    // terms_i==0 blocks grants; stop_i raised during WAIT_ADD
    clear_mon();
    add_lat = 10;
    terms   = 5'd0;
    fifo_wr = 4'b0110;
    tick(1);
    fifo_wr = 4'b0010;
    tick(1);
    fifo_wr = '0;
    tick(5);
    check("zero_terms_no_grant", n_dprst, 0);
    terms = 5'd1;
    k = 0;
    while (n_addv < 1 && k < 20) begin
      tick(1);
      k++;
    end
    check("stop_add_seen", n_addv, 1);
    stop = 1'b1;
    wait_done(1, 50, "stop_done_seen");
    tick(20);
    check("stop_single_job", n_dprst, 1);
    check("stop_done_count", n_done, 1);
    check("stop_done_ch", last_done_ch, 1);
    clear_mon();
    stop = 1'b0;
    c0   = cyc;
    wait_dprst(1, 10, "resume_started");
    check("resume_latency", last_dprst_cyc - c0, 1);
    wait_done(2, 200, "resume_done_seen");
    tick(10);
    check("resume_first_grant", (grant_q.size() > 0) ? grant_q[0] : -1, 2);
    check("resume_ch1_jobs", n_rdsig[1], 1);
    check("resume_ch2_jobs", n_rdsig[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
